// File: rtl/extended_gcd.sv
// Iterative extended Euclid: gcd(a_i, n_i) and the Bezout coefficient of a_i.
// Each quotient comes from a bit-serial restoring divider, so an iteration costs WORD_WIDTH+2 cycles.
module extended_gcd #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic        [WORD_WIDTH-1:0] a_i,
  input  logic        [WORD_WIDTH-1:0] n_i,
  output logic                         busy,
  output logic                         done,
  output logic signed [WORD_WIDTH-1:0] gcd_o,
  output logic signed [WORD_WIDTH-1:0] coeff_o,
  output logic signed [WORD_WIDTH-1:0] n_o
);

  localparam int CW = $clog2(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, UPDATE, DONE} state_t;

  state_t state, state_next;

  logic        [WORD_WIDTH-1:0] old_r, r;
  logic signed [WORD_WIDTH-1:0] old_s, s;
  logic        [WORD_WIDTH-1:0] rem, quo;
  logic        [CW-1:0]         cnt;
  logic        [WORD_WIDTH:0]   trial;
  logic        [WORD_WIDTH-1:0] prod;

  // Trial subtraction of one divider step; a clear MSB means the divisor fits.
  assign trial = {rem, quo[WORD_WIDTH-1]} - {1'b0, r};
  // Low WORD_WIDTH bits of q*s are the same whether operands are read as signed or not.
  assign prod  = quo * s;
  assign busy  = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = (r == '0) ? DONE : DIVIDE;
      DIVIDE:  if (cnt == LAST_BIT) state_next = UPDATE;
      UPDATE:  state_next = CHECK;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_r   <= '0;
      r       <= '0;
      old_s   <= '0;
      s       <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      gcd_o   <= '0;
      coeff_o <= '0;
      n_o     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            old_r <= a_i;
            r     <= n_i;
            old_s <= WORD_WIDTH'(1);
            s     <= '0;
            n_o   <= $signed(n_i);
          end
        end
        CHECK: begin
          // Results are registered on the way into DONE so they are valid with done.
          if (r == '0) begin
            done    <= 1'b1;
            gcd_o   <= $signed(old_r);
            coeff_o <= old_s;
          end else begin
            cnt <= '0;
            rem <= '0;
            quo <= old_r;
          end
        end
        DIVIDE: begin
          cnt <= cnt + 1'b1;
          if (!trial[WORD_WIDTH]) begin
            rem <= trial[WORD_WIDTH-1:0];
            quo <= {quo[WORD_WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WORD_WIDTH-2:0], quo[WORD_WIDTH-1]};
            quo <= {quo[WORD_WIDTH-2:0], 1'b0};
          end
        end
        UPDATE: begin
          old_r <= r;
          r     <= rem;
          old_s <= s;
          s     <= old_s - $signed(prod);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/extended_gcd.md
EXTENDED_GCD -- requirements
Module: extended_gcd

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, which sets the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to compute; sampled only in IDLE.
REQ-005 The block SHALL have port a_i, input, WORD_WIDTH bits, unsigned: the value to invert (e.g. RSA public exponent).
REQ-006 The block SHALL have port n_i, input, WORD_WIDTH bits, unsigned: the modulus; its MSB is 0 by contract.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-009 The block SHALL have port gcd_o, output, WORD_WIDTH bits, signed: gcd(a_i, n_i); feeds modular_inverse input a.
REQ-010 The block SHALL have port coeff_o, output, WORD_WIDTH bits, signed: Bezout coefficient s, with a_i*s + n_i*t = gcd; feeds coeff_i.
REQ-011 The block SHALL have port n_o, output, WORD_WIDTH bits, signed: n_i captured at start; feeds n.

Function
REQ-012 The FSM SHALL have exactly five states: IDLE, CHECK, DIVIDE, UPDATE and DONE.
REQ-013 In IDLE with start=1, the block SHALL load old_r=a_i, r=n_i, old_s=1, s=0 and n_o=n_i, and go to CHECK.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE with all outputs held.
REQ-015 In CHECK, the block SHALL go to DONE if r==0; otherwise it SHALL clear the bit counter and go to DIVIDE.
REQ-016 DIVIDE SHALL perform bit-serial restoring division of old_r by r: one quotient bit per cycle, MSB first, for exactly WORD_WIDTH cycles, then go to UPDATE.
REQ-017 UPDATE SHALL, in one cycle, set (old_r, r) to (r, remainder) and (old_s, s) to (s, old_s - q*s), then go to CHECK.
REQ-018 The q*s product SHALL be truncated to WORD_WIDTH signed bits; no overflow occurs because |s| <= n_i/2 < 2^(WORD_WIDTH-2).
REQ-019 DONE SHALL drive done=1, gcd_o=old_r and coeff_o=old_s (both registered), then go to IDLE.
REQ-020 For k division iterations, done SHALL be high in the cycle after rising edge k*(WORD_WIDTH+2)+1, counted from the start-accepting edge (edge 0).
REQ-021 start while busy=1 SHALL be ignored; done SHALL NOT be asserted for it and the inputs SHALL NOT be re-sampled.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.
REQ-023 gcd_o, coeff_o and n_o SHALL hold their values from done until the next DONE state or reset.
REQ-024 With a_i=0, the result SHALL be gcd_o=n_i, coeff_o=0 after 1 iteration.
REQ-025 With n_i=0, the result SHALL be gcd_o=a_i, coeff_o=1 after 0 iterations, with done high after edge 1.
REQ-026 With a_i=n_i=0, the result SHALL be gcd_o=0, coeff_o=1; the downstream stage flags the error.
REQ-027 Division by zero SHALL be unreachable, because CHECK gates entry to DIVIDE.

Reset
REQ-028 While rst=1, the block SHALL immediately enter IDLE, regardless of clock or state.
REQ-029 While rst=1, the block SHALL drive busy=0, done=0, gcd_o=0, coeff_o=0 and n_o=0, and clear all internal registers and counters.
REQ-030 Reset during any state, including mid-DIVIDE, SHALL abort the operation with no done pulse.
REQ-031 After reset deasserts, the first clock edge SHALL be able to accept start.

Verification
REQ-032 The bench SHALL cover: a_i=3, n_i=7, start pulse -> 3 iterations; done after edge 103 (W=32); gcd_o=1, coeff_o=-2; chained modular_inverse yields inv=5.
REQ-033 The bench SHALL cover: a_i=17, n_i=3120 -> 5 iterations; done after edge 171; gcd_o=1, coeff_o=-367 (inverse 2753).
REQ-034 The bench SHALL cover: a_i=6, n_i=9 -> gcd_o=3, coeff_o=-1; downstream error=1.
REQ-035 The bench SHALL cover: a_i=5, n_i=0 -> done after edge 1, gcd_o=5, coeff_o=1; then a_i=0, n_i=7 -> gcd_o=7, coeff_o=0.
REQ-036 The bench SHALL cover: start a_i=17, n_i=3120, pulse start again at edge 40 with a_i=3 -> exactly one done, at edge 171, with the 17/3120 results.
REQ-037 The bench SHALL cover: rst asserted at edge 50 of a 17/3120 run -> busy=0 and outputs=0 at once, no done; a fresh 3/7 run then yields the REQ-032 results.
